// File: rtl/pd_up_lte_pkg.sv
// pd_up_lte_pkg: shared constants, configuration types and state enum for the
// LTE transmit framing generator (pd_up_lte_inf).
package pd_up_lte_pkg;

    localparam int unsigned N_SYMB    = 14;
    localparam int unsigned N_SF      = 10;
    localparam logic [3:0]  SYMB_LAST = 4'(N_SYMB - 1);
    localparam logic [3:0]  SF_LAST   = 4'(N_SF - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Raw per-bandwidth constants selected by i_sel.
    typedef struct packed {
        logic [4:0]  xant_max;
        logic [11:0] fft;
        logic [11:0] lcp;
        logic [11:0] scp;
    } sel_const_t;

    // Derived configuration used by the counters and decoders.
    typedef struct packed {
        logic [4:0]  xant_max;
        logic [11:0] llen_m1;
        logic [11:0] slen_m1;
        logic [11:0] lcp;
        logic [11:0] scp;
    } cfg_t;

    function automatic sel_const_t sel_const(input logic [1:0] sel);
        sel_const_t c;
        case (sel)
            2'd0:    c = '{xant_max: 5'd31, fft: 12'd512,  lcp: 12'd40,  scp: 12'd36};
            2'd1:    c = '{xant_max: 5'd15, fft: 12'd1024, lcp: 12'd80,  scp: 12'd72};
            2'd2:    c = '{xant_max: 5'd15, fft: 12'd1024, lcp: 12'd80,  scp: 12'd72};
            2'd3:    c = '{xant_max: 5'd7,  fft: 12'd2048, lcp: 12'd160, scp: 12'd144};
            default: c = '{xant_max: 5'd31, fft: 12'd512,  lcp: 12'd40,  scp: 12'd36};
        endcase
        return c;
    endfunction

    // Symbols 0 and 7 of a subframe carry the long cyclic prefix.
    function automatic logic is_long_symb(input logic [3:0] symb);
        return (symb == 4'd0) || (symb == 4'd7);
    endfunction

endpackage

// File: rtl/pd_up_lte_len_lut.sv
// pd_up_lte_len_lut: registered configuration lookup. The register only
// updates on load_i, so its output is the latched configuration in force.
module pd_up_lte_len_lut
    import pd_up_lte_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [1:0] sel_i,
    output cfg_t       cfg_o
);

    localparam cfg_t RST_CFG = '{xant_max: 5'd31, llen_m1: 12'd551, slen_m1: 12'd547,
                                 lcp: 12'd40, scp: 12'd36};

    cfg_t       cfg_d;
    cfg_t       cfg_q;
    sel_const_t raw_s;

    // Derive symbol lengths (minus one) and CP lengths for the requested bandwidth.
    always_comb begin
        raw_s         = sel_const(sel_i);
        cfg_d.xant_max = raw_s.xant_max;
        cfg_d.llen_m1  = raw_s.fft + raw_s.lcp - 12'd1;
        cfg_d.slen_m1  = raw_s.fft + raw_s.scp - 12'd1;
        cfg_d.lcp      = raw_s.lcp;
        cfg_d.scp      = raw_s.scp;
    end

    // Hold the configuration, replacing it only at a latch point.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q <= RST_CFG;
        end else if (load_i) begin
            cfg_q <= cfg_d;
        end else begin
            cfg_q <= cfg_q;
        end
    end

    assign cfg_o = cfg_q;

endmodule

// File: rtl/pd_up_lte_inf.sv
// pd_up_lte_inf: LTE transmit framing generator for the antenna-interleaved
// sample bus. Counts antenna slot / point / symbol / subframe, announces the
// current slot on registered outputs, requests symbols ahead of time.
// Optional feature macro: PD_UP_LTE_UFLOW_EN enables i_rdy sampling, o_mute
// and the sticky o_uflow flag; when undefined those outputs are tied to 0.
module pd_up_lte_inf
    import pd_up_lte_pkg::*;
#(
    parameter int unsigned REQ_LEAD = 64
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] i_sel,
    input  logic       i_en,
    input  logic       i_sync,
    input  logic       i_rdy,
    output logic       o_fram,
    output logic       o_radio,
    output logic [4:0] o_ant,
    output logic [3:0] o_symb,
    output logic [3:0] o_sf,
    output logic       o_cp,
    output logic       o_req,
    output logic       o_mute,
    output logic       o_uflow
);

    localparam logic [11:0] LEAD_C = 12'(REQ_LEAD);

    state_t      state_q, state_d;
    logic [4:0]  ant_q,   ant_d;
    logic [11:0] point_q, point_d;
    logic [3:0]  symb_q,  symb_d;
    logic [3:0]  sf_q,    sf_d;

    cfg_t        cfg_s;
    logic        load_s;
    logic [11:0] cur_len_m1_s;
    logic [11:0] nxt_len_m1_s;
    logic [11:0] nxt_cp_s;
    logic        run_d_s;

    logic        fram_d, radio_d, cp_d, req_d;
    logic        fram_q, radio_q, cp_q, req_q;
    logic [4:0]  ant_out_q;
    logic [3:0]  symb_out_q, sf_out_q;

    // Latch a new configuration when starting up or entering symbol 0 point 0.
    assign load_s = (state_d == RUN) && (ant_d == 5'd0) && (point_d == 12'd0) && (symb_d == 4'd0);

    pd_up_lte_len_lut u_len_lut (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .load_i (load_s),
        .sel_i  (i_sel),
        .cfg_o  (cfg_s)
    );

    assign cur_len_m1_s = is_long_symb(symb_q) ? cfg_s.llen_m1 : cfg_s.slen_m1;

    // State and counter register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ant_q   <= 5'd0;
            point_q <= 12'd0;
            symb_q  <= 4'd0;
            sf_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            ant_q   <= ant_d;
            point_q <= point_d;
            symb_q  <= symb_d;
            sf_q    <= sf_d;
        end
    end

    // Next state and counter advance; disable beats realign, realign beats advance.
    always_comb begin
        state_d = state_q;
        ant_d   = ant_q;
        point_d = point_q;
        symb_d  = symb_q;
        sf_d    = sf_q;
        case (state_q)
            IDLE: begin
                ant_d   = 5'd0;
                point_d = 12'd0;
                symb_d  = 4'd0;
                sf_d    = 4'd0;
                if (i_en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!i_en) begin
                    state_d = IDLE;
                    ant_d   = 5'd0;
                    point_d = 12'd0;
                    symb_d  = 4'd0;
                    sf_d    = 4'd0;
                end else if (i_sync) begin
                    ant_d   = 5'd0;
                    point_d = 12'd0;
                    symb_d  = 4'd0;
                    sf_d    = 4'd0;
                end else if (ant_q == cfg_s.xant_max) begin
                    ant_d = 5'd0;
                    if (point_q == cur_len_m1_s) begin
                        point_d = 12'd0;
                        if (symb_q == SYMB_LAST) begin
                            symb_d = 4'd0;
                            if (sf_q == SF_LAST) begin
                                sf_d = 4'd0;
                            end else begin
                                sf_d = sf_q + 4'd1;
                            end
                        end else begin
                            symb_d = symb_q + 4'd1;
                        end
                    end else begin
                        point_d = point_q + 12'd1;
                    end
                end else begin
                    ant_d = ant_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ant_d   = 5'd0;
                point_d = 12'd0;
                symb_d  = 4'd0;
                sf_d    = 4'd0;
            end
        endcase
    end

    // Decode the slot outputs from next state so they line up with the counters.
    // At a latch point point_d is 0, so the old configuration cannot mis-decode cp/req.
    always_comb begin
        run_d_s      = (state_d == RUN);
        nxt_len_m1_s = is_long_symb(symb_d) ? cfg_s.llen_m1 : cfg_s.slen_m1;
        nxt_cp_s     = is_long_symb(symb_d) ? cfg_s.lcp : cfg_s.scp;
        if (run_d_s) begin
            fram_d  = (ant_d == 5'd0) && (point_d == 12'd0) && (symb_d == 4'd0);
            radio_d = fram_d && (sf_d == 4'd0);
            cp_d    = (point_d < nxt_cp_s);
            req_d   = (ant_d == cfg_s.xant_max) && (point_d == (nxt_len_m1_s - LEAD_C));
        end else begin
            fram_d  = 1'b0;
            radio_d = 1'b0;
            cp_d    = 1'b0;
            req_d   = 1'b0;
        end
    end

    // Output register for the slot announcement.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fram_q     <= 1'b0;
            radio_q    <= 1'b0;
            ant_out_q  <= 5'd0;
            symb_out_q <= 4'd0;
            sf_out_q   <= 4'd0;
            cp_q       <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            fram_q     <= fram_d;
            radio_q    <= radio_d;
            ant_out_q  <= ant_d;
            symb_out_q <= symb_d;
            sf_out_q   <= sf_d;
            cp_q       <= cp_d;
            req_q      <= req_d;
        end
    end

    assign o_fram  = fram_q;
    assign o_radio = radio_q;
    assign o_ant   = ant_out_q;
    assign o_symb  = symb_out_q;
    assign o_sf    = sf_out_q;
    assign o_cp    = cp_q;
    assign o_req   = req_q;

`ifdef PD_UP_LTE_UFLOW_EN
    logic last_s;
    logic mute_d, mute_q;
    logic uflow_d, uflow_q;

    // Last cycle of the current symbol: i_rdy decides the fate of the next one.
    assign last_s = (state_q == RUN) && (ant_q == cfg_s.xant_max) && (point_q == cur_len_m1_s);

    // Mute follows the i_rdy sample for a whole symbol; underflow is sticky within a run.
    always_comb begin
        if (!run_d_s || (state_q == IDLE)) begin
            mute_d  = 1'b0;
            uflow_d = 1'b0;
        end else if (last_s) begin
            mute_d  = !i_rdy;
            uflow_d = uflow_q | !i_rdy;
        end else begin
            mute_d  = mute_q;
            uflow_d = uflow_q;
        end
    end

    // Mute / underflow register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mute_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            mute_q  <= mute_d;
            uflow_q <= uflow_d;
        end
    end

    assign o_mute  = mute_q;
    assign o_uflow = uflow_q;
`else
    logic rdy_unused_s;
    assign rdy_unused_s = i_rdy;
    assign o_mute       = 1'b0;
    assign o_uflow      = 1'b0;
`endif

endmodule
